// File: rtl/uart_receiver_if.sv
// -----------------------------------------------------------------------------
// uart_receiver_if
//
// Bundles the serial input, the 16x baud enable and the received-byte strobe
// group of the UART receiver.
//
//   rx            serial line, idle high, asynchronous to the clock
//   s_tick        16x baud enable, one clock wide
//   rx_data       last received byte, LSB = first bit on the line
//   rx_done_tick  one-cycle strobe; rx_data and frame_err valid in that cycle
//   frame_err     1 when the stop bit of the last frame sampled low
//
// Modports:
//   master  the line/tick driver and byte consumer (testbench, top level)
//   slave   the receiver itself
// -----------------------------------------------------------------------------
interface uart_receiver_if #(
   parameter int DBITS = 8
);

   logic             rx;
   logic             s_tick;
   logic [DBITS-1:0] rx_data;
   logic             rx_done_tick;
   logic             frame_err;

   modport master (
      output rx,
      output s_tick,
      input  rx_data,
      input  rx_done_tick,
      input  frame_err
   );

   modport slave (
      input  rx,
      input  s_tick,
      output rx_data,
      output rx_done_tick,
      output frame_err
   );

endinterface : uart_receiver_if

// File: rtl/uart_receiver.sv
// -----------------------------------------------------------------------------
// uart_receiver
//
// Serial UART receiver (8N1 by default) driven by a 16x oversampling enable.
// The asynchronous line is synchronized, a falling edge starts a frame, the
// start bit is validated at its centre, data bits are recovered LSB first by
// a 3-sample majority vote around each bit centre, and the stop bit is
// checked. Each byte is presented with a one-cycle strobe; there is no
// back-pressure, so the consumer must take it in that cycle.
//
// Parameters:
//   DBITS    data bits per frame (>= 2)
//   SB_TICK  oversampling ticks in the stop period (16 = 1, 24 = 1.5, 32 = 2)
//
// Ports:
//   clk_50MHz  system clock, rising edge
//   reset      asynchronous, active-high reset
//   bus        uart_receiver_if slave modport (rx, s_tick in;
//              rx_data, rx_done_tick, frame_err out)
// -----------------------------------------------------------------------------
module uart_receiver #(
   parameter int DBITS   = 8,
   parameter int SB_TICK = 16
) (
   input  logic              clk_50MHz,
   input  logic              reset,
   uart_receiver_if.slave    bus
);

   localparam int NW = (DBITS > 1) ? $clog2(DBITS) : 1;

   localparam logic [4:0]    S_BIT_LAST  = 5'd15;
   localparam logic [4:0]    S_STOP_LAST = 5'(SB_TICK - 1);
   localparam logic [4:0]    S_VOTE_DONE = 5'd9;
   localparam logic [NW-1:0] N_LAST      = NW'(DBITS - 1);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   state_t           state;
   logic             rx_meta;
   logic             rx_s;
   logic [4:0]       s;
   logic [NW-1:0]    n;
   logic [DBITS-1:0] b;
   logic [2:0]       v;
   logic [DBITS-1:0] rx_data_q;
   logic             rx_done_q;
   logic             frame_err_q;

   logic             in_vote_window;
   logic             vote_live;
   logic             vote_held;

   function automatic logic maj3(input logic a, input logic b2, input logic c);
      return (a & b2) | (a & c) | (b2 & c);
   endfunction

   // -------------------------------------------------------------------------
   // Two-flop synchronizer for the asynchronous serial line.
   // NOTE: both flops reset to 1 (line idle) so leaving reset never looks
   // like a start-bit falling edge.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk_50MHz or posedge reset) begin
      if (reset) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= bus.rx;
         rx_s    <= rx_meta;
      end
   end

   // Samples are taken on the ticks where s = 7, 8, 9 of every bit period.
   assign in_vote_window = (s == 5'd7) || (s == 5'd8) || (s == 5'd9);

   // At the s = 9 tick the third sample is still on rx_s, not yet in v, so
   // the start-bit check votes over the two stored samples plus the live one.
   assign vote_live = maj3(v[1], v[0], rx_s);

   // From s = 10 onward all three samples of the current bit sit in v.
   assign vote_held = maj3(v[2], v[1], v[0]);

   // -------------------------------------------------------------------------
   // Receive FSM with registered outputs.
   // NOTE: all state here uses non-blocking assignments so every branch sees
   // the pre-edge values of s, n, v and b regardless of statement order.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk_50MHz or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         s           <= '0;
         n           <= '0;
         b           <= '0;
         v           <= '0;
         rx_data_q   <= '0;
         rx_done_q   <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         // NOTE: the strobe defaults low every cycle and is raised only in the
         // stop-bit branch below, so it can never stretch past one clock.
         rx_done_q <= 1'b0;

         if (bus.s_tick && (state != IDLE) && in_vote_window) begin
            v <= {v[1:0], rx_s};
         end

         case (state)
            IDLE: begin
               // A tick coinciding with this transition is deliberately not
               // counted: s starts from 0 on the first tick seen in START.
               if (!rx_s) begin
                  state <= START;
                  s     <= '0;
               end
            end

            START: begin
               if (bus.s_tick) begin
                  if ((s == S_VOTE_DONE) && vote_live) begin
                     // Line is back high at the start-bit centre: noise.
                     state <= IDLE;
                     s     <= '0;
                  end else if (s == S_BIT_LAST) begin
                     state <= DATA;
                     s     <= '0;
                     n     <= '0;
                  end else begin
                     s <= s + 5'd1;
                  end
               end
            end

            DATA: begin
               if (bus.s_tick) begin
                  if (s == S_BIT_LAST) begin
                     // Right shift: the first bit received ends up in b[0].
                     b <= {vote_held, b[DBITS-1:1]};
                     s <= '0;
                     if (n == N_LAST) begin
                        state <= STOP;
                     end else begin
                        n <= n + 1'b1;
                     end
                  end else begin
                     s <= s + 5'd1;
                  end
               end
            end

            STOP: begin
               if (bus.s_tick) begin
                  if (s == S_STOP_LAST) begin
                     // The byte is handed over even when the stop bit was low.
                     rx_data_q   <= b;
                     frame_err_q <= ~vote_held;
                     rx_done_q   <= 1'b1;
                     state       <= IDLE;
                     s           <= '0;
                  end else begin
                     s <= s + 5'd1;
                  end
               end
            end

            default: begin
               state <= IDLE;
               s     <= '0;
            end
         endcase
      end
   end

   assign bus.rx_data      = rx_data_q;
   assign bus.rx_done_tick = rx_done_q;
   assign bus.frame_err    = frame_err_q;

endmodule : uart_receiver
